multicycle_control: RTL and testbench
=====================================

// Module: multicycle_control
// PURPOSE
//  Main control FSM for the multicycle RV32I-subset datapath. Reads the latched IR word and the ALU
//  zero flag, and drives every datapath enable and mux select, one state per cycle.
//  Supports lw, sw, add/sub/and/or, addi/andi/ori and beq. The PC advances only when an instruction
//  retires, so branch-target arithmetic in DECODE uses the un-incremented PC.
// PARAMETERS
//  INST_W   32  width of the instruction input
//  ALUC_W   4   ALU control width (0000 AND, 0001 OR, 0010 ADD, 0110 SUB)
// PORTS
//  clk         in   1       rising-edge clock
//  reset       in   1       asynchronous, active-high reset
//  inst        in   INST_W  IR output
//  zero        in   1       ALU zero flag (combinational, current cycle)
//  PCWrite     out  1       PC load enable
//  IorD        out  1       memory address select: 0 = PC, 1 = ALUOut
//  memRead     out  1       memory read enable
//  memWrite    out  1       memory write enable
//  IRWrite     out  1       IR load enable
//  MemtoReg    out  1       register write-data select: 1 = MDR, 0 = ALUOut
//  PCSource    out  1       next-PC select: 1 = ALUOut, 0 = ALU result
//  ALUSrcA     out  1       ALU A select: 1 = A register, 0 = PC
//  ALUSrcB     out  2       ALU B select: 00 = B, 01 = 4, 10 = imm
//  regWrite    out  1       register-file write enable
//  ALUControl  out  ALUC_W  ALU operation
//  state       out  4       current state, for debug
//  illegal     out  1       sticky illegal-instruction flag
// BEHAVIOUR
//  - Reset: asynchronous. state <= FETCH and illegal <= 0. While reset is high, all enables are 0,
//    ALUSrcB = 00 and ALUControl = 0010. Reset mid-instruction abandons it; there are no partial writes after release.
//  - Outputs are decoded from state (Moore). Exception: PCWrite in BRANCH is state & zero (Mealy).
//  - Unlisted signals are 0 in each state. "PC+4" = ALUSrcA 0, ALUSrcB 01, ADD, PCSource 0, PCWrite 1.
//  - FETCH: memRead, IorD 0, IRWrite. Next: DECODE.
//  - DECODE: ALUSrcA 0, ALUSrcB 10, ADD, so ALUOut <= PC+imm. Next by opcode:
//    0000011/0100011 -> MEM_ADDR; 0110011 -> EXEC_R; 0010011 -> EXEC_I; 1100011 with funct3 000 -> BRANCH;
//    anything else -> ILLEGAL handling (see CONFIGURATION).
//  - MEM_ADDR: ALUSrcA 1, ALUSrcB 10, ADD. Next: MEM_READ for lw, MEM_WRITE for sw.
//  - MEM_READ: memRead, IorD 1. Next: MEM_WB.
//  - MEM_WB: regWrite, MemtoReg 1, plus PC+4. Next: FETCH.
//  - MEM_WRITE: memWrite, IorD 1, plus PC+4 (ALU is free; address comes from ALUOut). Next: FETCH.
//  - EXEC_R: ALUSrcA 1, ALUSrcB 00, ALUControl from funct7b5/funct3:
//    {0,000} ADD, {1,000} SUB, {0,111} AND, {0,110} OR; other combinations are illegal. Next: ALU_WB.
//  - EXEC_I: ALUSrcA 1, ALUSrcB 10, funct3 000/111/110 -> ADD/AND/OR. Next: ALU_WB.
//  - ALU_WB: regWrite, MemtoReg 0, plus PC+4 (regfile captures the old ALUOut on the same edge). Next: FETCH.
//  - BRANCH: ALUSrcA 1, ALUSrcB 00, SUB.
//    zero = 1: PCWrite 1, PCSource 1 (target from DECODE), next FETCH. zero = 0: next PC_INC.
//  - PC_INC: PC+4. Next: FETCH.
//  - Latency in cycles: lw 5, sw 4, R-type 4, I-type 4, beq taken 3, beq not taken 4.
//  - Illegal funct combinations detected in EXEC_R/EXEC_I are routed as illegal opcodes, decided in DECODE.
// CONFIGURATION
//  - CTRL_ILLEGAL_HALT_EN defined: an illegal instruction goes to HALT and sets illegal = 1.
//    HALT is absorbing (all enables 0) until reset.
//  - CTRL_ILLEGAL_HALT_EN undefined: an illegal instruction goes to PC_INC (NOP) and illegal is tied to 0.
// STRUCTURE
//  - Shared package riscv_mc_pkg holds the state encodings (4-bit localparams), opcode constants,
//    ALUSrcB codes and ALU control codes. The datapath and the bench use the same package.
//  - Sub-module alu_control is combinational: {aluop[1:0], funct3, funct7b5} -> ALUControl plus a func_illegal flag.
//    The FSM supplies aluop (00 ADD, 01 SUB, 10 R-type, 11 I-type).
// TESTING
//  - addi x3,x0,20 (0x01400193) -> FETCH, DECODE, EXEC_I (ALUSrcB 10, ALUControl 0010), ALU_WB
//    (regWrite 1, PCWrite 1, ALUSrcB 01). 4 cycles.
//  - lw x8,120(x3) (0x0781A403) -> memRead & IorD 1 in cycle 4; cycle 5 has regWrite & MemtoReg 1 and PCWrite 1.
//  - sub x11,x10,x8 (0x408505B3) -> ALUControl 0110 in EXEC_R. Equivalent add (0x008505B3) -> 0010.
//  - beq x0,x0,+8 (0x00000463) with zero = 1 -> cycle 3 has PCWrite 1, PCSource 1.
//    With zero = 0 -> PC_INC in cycle 4 with PCSource 0.
//  - Opcode 0x7F -> with the macro: HALT and illegal 1, no further enables until reset.
//    Without the macro: PC_INC, then FETCH.
//  - Assert reset during MEM_READ of lw -> state FETCH immediately, all enables 0 while reset is high,
//    and FETCH outputs on the first cycle after release.

Source files
------------

// File: rtl/riscv_mc_pkg.sv
// rtl/riscv_mc_pkg.sv - shared encodings for the multicycle RV32I-subset control path
package riscv_mc_pkg;

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEM_ADDR  = 4'd2,
    MEM_READ  = 4'd3,
    MEM_WB    = 4'd4,
    MEM_WRITE = 4'd5,
    EXEC_R    = 4'd6,
    EXEC_I    = 4'd7,
    ALU_WB    = 4'd8,
    BRANCH    = 4'd9,
    PC_INC    = 4'd10,
    HALT      = 4'd11
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] SRCB_B   = 2'b00;
  localparam logic [1:0] SRCB_4   = 2'b01;
  localparam logic [1:0] SRCB_IMM = 2'b10;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  localparam logic [1:0] ALUOP_ADD = 2'b00;
  localparam logic [1:0] ALUOP_SUB = 2'b01;
  localparam logic [1:0] ALUOP_R   = 2'b10;
  localparam logic [1:0] ALUOP_I   = 2'b11;

endpackage

// File: rtl/alu_control.sv
// rtl/alu_control.sv - combinational aluop/funct decode to ALU operation and funct legality
module alu_control
  import riscv_mc_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  output logic [3:0] alu_control,
  output logic       func_illegal
);

  always_comb begin
    alu_control  = ALU_ADD;
    func_illegal = 1'b0;
    case (aluop)
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_R: begin
        case ({funct7b5, funct3})
          4'b0000: alu_control = ALU_ADD;
          4'b1000: alu_control = ALU_SUB;
          4'b0111: alu_control = ALU_AND;
          4'b0110: alu_control = ALU_OR;
          default: func_illegal = 1'b1;
        endcase
      end
      // funct7 bit 5 is an immediate bit for I-type, so it is ignored here
      ALUOP_I: begin
        case (funct3)
          3'b000:  alu_control = ALU_ADD;
          3'b111:  alu_control = ALU_AND;
          3'b110:  alu_control = ALU_OR;
          default: func_illegal = 1'b1;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - main multicycle control FSM; CTRL_ILLEGAL_HALT_EN selects halt-on-illegal
module multicycle_control
  import riscv_mc_pkg::*;
#(
  parameter int INST_W = 32,
  parameter int ALUC_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [INST_W-1:0] inst,
  input  logic              zero,
  output logic              PCWrite,
  output logic              IorD,
  output logic              memRead,
  output logic              memWrite,
  output logic              IRWrite,
  output logic              MemtoReg,
  output logic              PCSource,
  output logic              ALUSrcA,
  output logic [1:0]        ALUSrcB,
  output logic              regWrite,
  output logic [ALUC_W-1:0] ALUControl,
  output logic [3:0]        state,
  output logic              illegal
);

`ifdef CTRL_ILLEGAL_HALT_EN
  localparam state_t ILL_NEXT = HALT;
`else
  localparam state_t ILL_NEXT = PC_INC;
`endif

  state_t     cur, nxt;
  logic [1:0] aluop;
  logic [3:0] aluc;
  logic       exec_func_unused;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7b5;
  logic [1:0] dec_aluop;
  logic [3:0] dec_aluc_unused;
  logic       dec_func_ill;
  logic       inst_bits_unused;

  assign opcode           = inst[6:0];
  assign funct3           = inst[14:12];
  assign funct7b5         = inst[30];
  assign inst_bits_unused = ^{inst[INST_W-1:31], inst[29:15], inst[11:7]};

  alu_control u_alu_control (
    .aluop        (aluop),
    .funct3       (funct3),
    .funct7b5     (funct7b5),
    .alu_control  (aluc),
    .func_illegal (exec_func_unused)
  );

  // Second decoder checks funct legality up front so EXEC states never see a bad funct
  assign dec_aluop = (opcode == OP_R) ? ALUOP_R : ALUOP_I;

  alu_control u_dec_check (
    .aluop        (dec_aluop),
    .funct3       (funct3),
    .funct7b5     (funct7b5),
    .alu_control  (dec_aluc_unused),
    .func_illegal (dec_func_ill)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cur <= FETCH;
    else       cur <= nxt;
  end

  always_comb begin
    nxt      = cur;
    PCWrite  = 1'b0;
    IorD     = 1'b0;
    memRead  = 1'b0;
    memWrite = 1'b0;
    IRWrite  = 1'b0;
    MemtoReg = 1'b0;
    PCSource = 1'b0;
    ALUSrcA  = 1'b0;
    ALUSrcB  = SRCB_B;
    regWrite = 1'b0;
    aluop    = ALUOP_ADD;
    case (cur)
      FETCH: begin
        memRead = 1'b1;
        IRWrite = 1'b1;
        nxt     = DECODE;
      end
      DECODE: begin
        ALUSrcB = SRCB_IMM;
        case (opcode)
          OP_LOAD, OP_STORE: nxt = MEM_ADDR;
          OP_R:              nxt = dec_func_ill ? ILL_NEXT : EXEC_R;
          OP_I:              nxt = dec_func_ill ? ILL_NEXT : EXEC_I;
          OP_BRANCH:         nxt = (funct3 == 3'b000) ? BRANCH : ILL_NEXT;
          default:           nxt = ILL_NEXT;
        endcase
      end
      MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        nxt     = (opcode == OP_LOAD) ? MEM_READ : MEM_WRITE;
      end
      MEM_READ: begin
        memRead = 1'b1;
        IorD    = 1'b1;
        nxt     = MEM_WB;
      end
      MEM_WB: begin
        regWrite = 1'b1;
        MemtoReg = 1'b1;
        ALUSrcB  = SRCB_4;
        PCWrite  = 1'b1;
        nxt      = FETCH;
      end
      MEM_WRITE: begin
        memWrite = 1'b1;
        IorD     = 1'b1;
        ALUSrcB  = SRCB_4;
        PCWrite  = 1'b1;
        nxt      = FETCH;
      end
      EXEC_R: begin
        ALUSrcA = 1'b1;
        aluop   = ALUOP_R;
        nxt     = ALU_WB;
      end
      EXEC_I: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        aluop   = ALUOP_I;
        nxt     = ALU_WB;
      end
      ALU_WB: begin
        regWrite = 1'b1;
        ALUSrcB  = SRCB_4;
        PCWrite  = 1'b1;
        nxt      = FETCH;
      end
      // Taken branch loads the DECODE-computed target held in ALUOut
      BRANCH: begin
        ALUSrcA  = 1'b1;
        aluop    = ALUOP_SUB;
        PCWrite  = zero;
        PCSource = zero;
        nxt      = zero ? FETCH : PC_INC;
      end
      PC_INC: begin
        ALUSrcB = SRCB_4;
        PCWrite = 1'b1;
        nxt     = FETCH;
      end
      HALT:    nxt = HALT;
      default: nxt = FETCH;
    endcase
    if (reset) begin
      PCWrite  = 1'b0;
      IorD     = 1'b0;
      memRead  = 1'b0;
      memWrite = 1'b0;
      IRWrite  = 1'b0;
      MemtoReg = 1'b0;
      PCSource = 1'b0;
      ALUSrcA  = 1'b0;
      ALUSrcB  = SRCB_B;
      regWrite = 1'b0;
      aluop    = ALUOP_ADD;
    end
  end

  assign ALUControl = ALUC_W'(aluc);
  assign state      = cur;

`ifdef CTRL_ILLEGAL_HALT_EN
  logic ill_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset)              ill_q <= 1'b0;
    else if (nxt == HALT)   ill_q <= 1'b1;
  end
  assign illegal = ill_q;
`else
  assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - self-checking bench for multicycle_control against a per-instruction sequence model
module tb_multicycle_control;
  import riscv_mc_pkg::*;

  logic        clk, reset, zero;
  logic [31:0] inst;
  logic        PCWrite, IorD, memRead, memWrite, IRWrite, MemtoReg, PCSource, ALUSrcA, regWrite, illegal;
  logic [1:0]  ALUSrcB;
  logic [3:0]  ALUControl, state;

  multicycle_control #(.INST_W(32), .ALUC_W(4)) dut (
    .clk(clk), .reset(reset), .inst(inst), .zero(zero),
    .PCWrite(PCWrite), .IorD(IorD), .memRead(memRead), .memWrite(memWrite),
    .IRWrite(IRWrite), .MemtoReg(MemtoReg), .PCSource(PCSource), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .regWrite(regWrite), .ALUControl(ALUControl),
    .state(state), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic pcw, iord, mrd, mwr, irw, m2r, pcs, srca;
    logic [1:0] srcb;
    logic rw;
    logic [3:0] aluc;
    logic ill;
  } obs_t;

  int   vectors = 0;
  int   miscompares = 0;
  obs_t exp_q[$];
  logic ill_m = 1'b0;
  logic halted = 1'b0;
  logic zs[8];

  function automatic obs_t observe();
    obs_t o;
    o.st = state; o.pcw = PCWrite; o.iord = IorD; o.mrd = memRead; o.mwr = memWrite;
    o.irw = IRWrite; o.m2r = MemtoReg; o.pcs = PCSource; o.srca = ALUSrcA;
    o.srcb = ALUSrcB; o.rw = regWrite; o.aluc = ALUControl; o.ill = illegal;
    return o;
  endfunction

  function automatic obs_t blank(input logic [3:0] s);
    obs_t o = '0;
    o.st = s; o.aluc = ALU_ADD; o.ill = ill_m;
    return o;
  endfunction

  function automatic obs_t pc4(input obs_t o);
    o.srca = 1'b0; o.srcb = 2'b01; o.aluc = ALU_ADD; o.pcs = 1'b0; o.pcw = 1'b1;
    return o;
  endfunction

  function automatic obs_t reset_view();
    obs_t o = '0;
    o.st = FETCH; o.aluc = ALU_ADD;
    return o;
  endfunction

  // Spec tables: legal R-type {funct7b5,funct3} and I-type funct3 with their ALU operations
  function automatic logic r_op(input logic f7, input logic [2:0] f3, output logic [3:0] op);
    op = ALU_ADD;
    if ({f7, f3} == 4'b0000) begin op = ALU_ADD; return 1'b1; end
    if ({f7, f3} == 4'b1000) begin op = ALU_SUB; return 1'b1; end
    if ({f7, f3} == 4'b0111) begin op = ALU_AND; return 1'b1; end
    if ({f7, f3} == 4'b0110) begin op = ALU_OR;  return 1'b1; end
    return 1'b0;
  endfunction

  function automatic logic i_op(input logic [2:0] f3, output logic [3:0] op);
    op = ALU_ADD;
    if (f3 == 3'b000) begin op = ALU_ADD; return 1'b1; end
    if (f3 == 3'b111) begin op = ALU_AND; return 1'b1; end
    if (f3 == 3'b110) begin op = ALU_OR;  return 1'b1; end
    return 1'b0;
  endfunction

  task automatic build(input logic [31:0] w);
    logic [6:0] op = w[6:0];
    logic [2:0] f3 = w[14:12];
    logic [3:0] code;
    obs_t c;
    exp_q.delete();
    c = blank(FETCH); c.mrd = 1; c.irw = 1; exp_q.push_back(c);
    c = blank(DECODE); c.srcb = 2'b10; exp_q.push_back(c);
    if (op == OP_LOAD || op == OP_STORE) begin
      c = blank(MEM_ADDR); c.srca = 1; c.srcb = 2'b10; exp_q.push_back(c);
      if (op == OP_LOAD) begin
        c = blank(MEM_READ); c.mrd = 1; c.iord = 1; exp_q.push_back(c);
        c = pc4(blank(MEM_WB)); c.rw = 1; c.m2r = 1; exp_q.push_back(c);
      end else begin
        c = pc4(blank(MEM_WRITE)); c.mwr = 1; c.iord = 1; exp_q.push_back(c);
      end
    end else if (op == OP_R && r_op(w[30], f3, code)) begin
      c = blank(EXEC_R); c.srca = 1; c.aluc = code; exp_q.push_back(c);
      c = pc4(blank(ALU_WB)); c.rw = 1; exp_q.push_back(c);
    end else if (op == OP_I && i_op(f3, code)) begin
      c = blank(EXEC_I); c.srca = 1; c.srcb = 2'b10; c.aluc = code; exp_q.push_back(c);
      c = pc4(blank(ALU_WB)); c.rw = 1; exp_q.push_back(c);
    end else if (op == OP_BRANCH && f3 == 3'b000) begin
      c = blank(BRANCH); c.srca = 1; c.aluc = ALU_SUB;
      if (zs[2]) begin c.pcw = 1; c.pcs = 1; exp_q.push_back(c); end
      else begin exp_q.push_back(c); exp_q.push_back(pc4(blank(PC_INC))); end
    end else begin
`ifdef CTRL_ILLEGAL_HALT_EN
      ill_m = 1'b1;
      halted = 1'b1;
      repeat (3) exp_q.push_back(blank(HALT));
`else
      exp_q.push_back(pc4(blank(PC_INC)));
`endif
    end
  endtask

  task automatic do_reset(input string name);
    obs_t got;
    reset = 1'b1;
    #1;
    got = observe(); vectors++;
    if (got !== reset_view()) begin
      miscompares++;
      $display("FAIL %s_reset_assert: got %h want %h", name, got, reset_view());
    end
    @(posedge clk); #1;
    got = observe(); vectors++;
    if (got !== reset_view()) begin
      miscompares++;
      $display("FAIL %s_reset_hold: got %h want %h", name, got, reset_view());
    end
    reset = 1'b0;
    ill_m = 1'b0;
    halted = 1'b0;
  endtask

  // Runs one instruction from FETCH; ncyc < 0 runs the whole expected sequence
  task automatic run_inst(input logic [31:0] w, input string name, input int zforce, input int ncyc);
    obs_t got;
    int n;
    for (int k = 0; k < 8; k++) zs[k] = 1'($urandom_range(0, 1));
    if (zforce >= 0) zs[2] = 1'(zforce);
    build(w);
    inst = w;
    n = (ncyc < 0) ? exp_q.size() : ncyc;
    for (int k = 0; k < n; k++) begin
      zero = zs[k];
      @(negedge clk);
      got = observe(); vectors++;
      if (got !== exp_q[k]) begin
        miscompares++;
        $display("FAIL %s cyc%0d inst %h: got %h want %h", name, k, w, got, exp_q[k]);
      end
      @(posedge clk); #1;
    end
    if (halted) do_reset(name);
  endtask

  task automatic test_reset();
    obs_t got;
    #1;
    got = observe(); vectors++;
    if (got !== reset_view()) begin
      miscompares++;
      $display("FAIL reset_state: got %h want %h", got, reset_view());
    end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_itype();
    run_inst(32'h01400193, "addi", -1, -1);
    run_inst(32'h0FF1F193, "andi", -1, -1);
    run_inst(32'h0071E193, "ori", -1, -1);
  endtask

  task automatic test_mem();
    run_inst(32'h0781A403, "lw", -1, -1);
    run_inst(32'h0681A423, "sw", -1, -1);
  endtask

  task automatic test_rtype();
    run_inst(32'h408505B3, "sub", -1, -1);
    run_inst(32'h008505B3, "add", -1, -1);
    run_inst(32'h008575B3, "and", -1, -1);
    run_inst(32'h008565B3, "or", -1, -1);
  endtask

  task automatic test_branch();
    run_inst(32'h00000463, "beq_taken", 1, -1);
    run_inst(32'h00000463, "beq_not_taken", 0, -1);
  endtask

  task automatic test_illegal();
    run_inst(32'h0000007F, "illegal_opcode", -1, -1);
    run_inst(32'h408575B3, "illegal_rfunct", -1, -1);
    run_inst(32'h00001463, "illegal_bne", -1, -1);
    run_inst(32'h01400193, "after_illegal", -1, -1);
  endtask

  task automatic test_reset_mid();
    obs_t got;
    run_inst(32'h0781A403, "lw_part", -1, 3);
    @(negedge clk);
    vectors++;
    if (state !== MEM_READ) begin
      miscompares++;
      $display("FAIL reset_mid_state: got %0d want %0d", state, MEM_READ);
    end
    #2;
    do_reset("reset_mid");
    run_inst(32'h01400193, "post_reset_addi", -1, -1);
  endtask

  task automatic test_random();
    logic [6:0] ops[6];
    logic [2:0] goodf3[3];
    logic [31:0] w;
    ops[0] = OP_LOAD; ops[1] = OP_STORE; ops[2] = OP_R;
    ops[3] = OP_I; ops[4] = OP_BRANCH; ops[5] = 7'h00;
    goodf3[0] = 3'b000; goodf3[1] = 3'b111; goodf3[2] = 3'b110;
    for (int i = 0; i < 60; i++) begin
      w = $urandom;
      w[6:0] = ops[$urandom_range(0, 5)];
      if (w[6:0] == 7'h00) w[6:0] = 7'($urandom);
      if ($urandom_range(0, 3) != 0) begin
        w[14:12] = goodf3[$urandom_range(0, 2)];
        if (w[6:0] == OP_R && w[14:12] != 3'b000) w[30] = 1'b0;
        if (w[6:0] == OP_BRANCH) w[14:12] = 3'b000;
      end
      run_inst(w, "random", -1, -1);
    end
  endtask

  initial begin
    clk = 1'b0;
    reset = 1'b1;
    inst = 32'h0;
    zero = 1'b0;
    test_reset();
    test_itype();
    test_mem();
    test_rtype();
    test_branch();
    test_illegal();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
